// File: rtl/ads1278_dout_emu_if.sv
// Host-facing serial/sample bus of the ADS1278 DOUT emulator.
// master = host/sample source side, slave = emulator side.
interface ads1278_dout_emu_if;
  logic         i_fsync;
  logic         i_sclk;
  logic [7:0]   o_dout;
  logic [191:0] i_smp_data;
  logic         i_smp_valid;
  logic         o_smp_ready;
  logic         o_frame_done;
  logic         o_underrun;

  modport master (
    output i_fsync, i_sclk, i_smp_data, i_smp_valid,
    input  o_dout, o_smp_ready, o_frame_done, o_underrun
  );

  modport slave (
    input  i_fsync, i_sclk, i_smp_data, i_smp_valid,
    output o_dout, o_smp_ready, o_frame_done, o_underrun
  );
endinterface

// File: rtl/ads1278_dout_emu.sv
// Emulates the 8-channel ADS1278 DOUT serial output (24-bit frames, fsync/sclk host timing).
// Optional macro ADS1278_EMU_RAMP_EN: underrun frames carry a ramp instead of repeating the last set.
module ads1278_dout_emu #(
  parameter logic [7:0] P_CH_EN = 8'b1111_1111
) (
  input  logic               w_ads1278_clk,
  input  logic               w_read_cnt_rst,
  ads1278_dout_emu_if.slave  bus
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 24;

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;

  state_t                            r_state;
  logic                              r_fsync_d, r_sclk_d;
  logic                              r_full, r_frame_done, r_underrun;
  logic [4:0]                        r_bit_cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]   r_sr, r_hold, r_last;
  logic [NUM_LANES-1:0][VEC_W-1:0]   w_under, w_src, w_load, w_shift, w_data;
  logic [NUM_LANES-1:0]              w_dout;
  logic                              w_fsync_rise, w_sclk_fall;
`ifdef ADS1278_EMU_RAMP_EN
  logic [VEC_W-1:0]                  r_ramp;
`endif

  assign w_fsync_rise = bus.i_fsync & ~r_fsync_d;
  // sclk falls are meaningless while the host still holds fsync high
  assign w_sclk_fall  = ~bus.i_sclk & r_sclk_d & ~bus.i_fsync;
  assign w_data       = bus.i_smp_data;
  assign w_src        = r_full ? r_hold : (bus.i_smp_valid ? w_data : w_under);

  genvar n;
  generate
    for (n = 0; n < NUM_LANES; n++) begin : g_lane
`ifdef ADS1278_EMU_RAMP_EN
      assign w_under[n] = r_ramp + VEC_W'(n);
`else
      assign w_under[n] = r_last[n];
`endif
      assign w_load[n]  = P_CH_EN[n] ? w_src[n] : '0;
      assign w_shift[n] = {r_sr[n][VEC_W-2:0], 1'b0};
      assign w_dout[n]  = r_sr[n][VEC_W-1];
    end
  endgenerate

  assign bus.o_dout       = w_dout;
  assign bus.o_smp_ready  = ~r_full;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_underrun   = r_underrun;

  always_ff @(posedge w_ads1278_clk or posedge w_read_cnt_rst) begin
    if (w_read_cnt_rst) begin
      r_state      <= IDLE;
      r_fsync_d    <= 1'b0;
      r_sclk_d     <= 1'b1;
      r_full       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_hold       <= '0;
      r_last       <= '0;
`ifdef ADS1278_EMU_RAMP_EN
      r_ramp       <= '0;
`endif
    end else begin
      r_fsync_d    <= bus.i_fsync;
      r_sclk_d     <= bus.i_sclk;
      r_frame_done <= 1'b0;
      if (w_fsync_rise) begin
        // a rise in any state (including mid-frame) restarts from a fresh load
        r_sr      <= w_load;
        r_last    <= w_src;
        r_bit_cnt <= '0;
        r_state   <= SYNC;
        if (r_full) begin
          r_full <= 1'b0;
        end else if (!bus.i_smp_valid) begin
          r_underrun <= 1'b1;
`ifdef ADS1278_EMU_RAMP_EN
          r_ramp     <= r_ramp + 1'b1;
`endif
        end
      end else begin
        if (bus.i_smp_valid && !r_full) begin
          r_hold <= w_data;
          r_full <= 1'b1;
        end
        case (r_state)
          SYNC: if (!bus.i_fsync) r_state <= SHIFT;
          SHIFT: begin
            if (w_sclk_fall) begin
              r_sr <= w_shift;
              if (r_bit_cnt == 5'd23) begin
                r_state      <= IDLE;
                r_frame_done <= 1'b1;
                r_bit_cnt    <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ads1278_dout_emu.sv
// Randomized scoreboard bench for ads1278_dout_emu: host model shifts frames, monitor checks them.
module tb_ads1278_dout_emu;
  localparam logic [7:0] TB_EN = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ads1278_dout_emu_if bus ();
  ads1278_dout_emu dut (.w_ads1278_clk(clk), .w_read_cnt_rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_frames = 0;

  logic [191:0] exp_q[$];
  logic [191:0] pend_q[$];
  logic [191:0] m_last;
  logic [23:0]  m_ramp;
  logic         m_under;
  logic [191:0] rx;

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what set a frame start transmits, from the pending queue / bypass / underrun rules
  function automatic logic [191:0] model_start(bit byp, logic [191:0] bd);
    logic [191:0] src, out;
    if (pend_q.size() > 0) src = pend_q.pop_front();
    else if (byp) src = bd;
    else begin
      m_under = 1'b1;
`ifdef ADS1278_EMU_RAMP_EN
      for (int c = 0; c < 8; c++) src[24*c +: 24] = m_ramp + 24'(c);
      m_ramp = m_ramp + 24'd1;
`else
      src = m_last;
`endif
    end
    m_last = src;
    out = src;
    for (int c = 0; c < 8; c++) if (!TB_EN[c]) out[24*c +: 24] = '0;
    return out;
  endfunction

  function automatic logic [191:0] rnd192();
    logic [191:0] v;
    for (int k = 0; k < 6; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_last = '0;
    m_ramp = '0;
    m_under = 1'b0;
  endtask

  task automatic offer(logic [191:0] d);
    @(negedge clk);
    chk("ready_before_offer", {191'd0, bus.o_smp_ready}, {191'd0, pend_q.size() == 0});
    bus.i_smp_valid = 1'b1;
    bus.i_smp_data  = d;
    pend_q.push_back(d);
    @(negedge clk);
    bus.i_smp_valid = 1'b0;
  endtask

  task automatic frame(int nbits, bit byp, logic [191:0] bd);
    logic [191:0] e;
    @(negedge clk);
    bus.i_fsync = 1'b1;
    if (byp) begin
      bus.i_smp_valid = 1'b1;
      bus.i_smp_data  = bd;
    end
    e = model_start(byp, bd);
    if (nbits == 24) begin
      exp_q.push_back(e);
      exp_frames++;
    end
    rx = '0;
    @(negedge clk);
    bus.i_fsync = 1'b0;
    bus.i_smp_valid = 1'b0;
    chk("underrun", {191'd0, bus.o_underrun}, {191'd0, m_under});
    chk("ready_after_fsync", {191'd0, bus.o_smp_ready}, {191'd0, pend_q.size() == 0});
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 8; c++) rx[24*c + 23 - i] = bus.o_dout[c];
      bus.i_sclk = 1'b0;
      repeat (2) @(negedge clk);
      bus.i_sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    if (nbits == 24) chk("dout_idle", {184'd0, bus.o_dout}, 192'd0);
  endtask

  // Monitor: each frame_done pulse retires one expected frame
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_frame_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("unexpected_frame_done", 192'd1, 192'd0);
        else chk("frame_data", rx, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] d;
    rst = 1'b1;
    bus.i_fsync = 1'b0;
    bus.i_sclk = 1'b1;
    bus.i_smp_valid = 1'b0;
    bus.i_smp_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dout", {184'd0, bus.o_dout}, 192'd0);
    chk("rst_ready", {191'd0, bus.o_smp_ready}, 192'd1);
    chk("rst_underrun", {191'd0, bus.o_underrun}, 192'd0);
    chk("rst_frame_done", {191'd0, bus.o_frame_done}, 192'd0);
    rst = 1'b0;

    // underrun straight after reset
    frame(24, 0, '0);

    // directed pattern on ch0 / ch7
    d = rnd192();
    d[23:0] = 24'hA5A5A5;
    d[191:168] = 24'h800001;
    offer(d);
    frame(24, 0, '0);

    // underrun repeats the previous set (ramp in the macro build)
    frame(24, 0, '0);
    frame(24, 0, '0);

    // bypass: data offered on the fsync rise cycle with holding empty
    frame(24, 1, rnd192());

    // abort after 10 bits, next frame must be clean
    offer(rnd192());
    frame(10, 0, '0);
    offer(rnd192());
    frame(24, 0, '0);

    // reset after 12 bits
    offer(rnd192());
    frame(12, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dout", {184'd0, bus.o_dout}, 192'd0);
    chk("midrst_ready", {191'd0, bus.o_smp_ready}, 192'd1);
    chk("midrst_underrun", {191'd0, bus.o_underrun}, 192'd0);
    rst = 1'b0;
    model_reset();
    offer(rnd192());
    frame(24, 0, '0);

    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0: begin offer(rnd192()); frame(24, 0, '0); end
        1: frame(24, 1, rnd192());
        default: frame(24, 0, '0);
      endcase
    end

    repeat (4) @(negedge clk);
    chk("frame_done_count", 192'(done_cnt), 192'(exp_frames));
    chk("scoreboard_drained", 192'(exp_q.size()), 192'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
